// File: rtl/cpu_bus_master_if.sv
// ---------------------------------------------------------------------------
// cpu_bus_master_if
//   Groups the signals of cpu_bus_master other than clock, reset and data:
//   the core request/response handshake and the system bus controls.
//
//   Core side : req, req_we, req_addr, req_wdata -> busy, ack, rdata, err
//   Bus side  : address, rw, strobe (from master), ready (from slave)
//
//   The bidirectional data bus is not in this interface. It is a plain
//   inout port on the master, so every tristate driver resolves on one
//   ordinary net.
//
//   Modports
//     master : the view used by cpu_bus_master
//     slave  : the view used by whatever sits around it (core plus bus slave)
// ---------------------------------------------------------------------------
interface cpu_bus_master_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              busy;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic [ADDR_W-1:0] address;
    logic              rw;
    logic              strobe;
    logic              ready;

    modport master (
        input  req, req_we, req_addr, req_wdata, ready,
        output busy, ack, rdata, err, address, rw, strobe
    );

    modport slave (
        output req, req_we, req_addr, req_wdata, ready,
        input  busy, ack, rdata, err, address, rw, strobe
    );
endinterface

// File: rtl/cpu_bus_master.sv
// ---------------------------------------------------------------------------
// cpu_bus_master
//   Bus interface unit between a CPU core and a shared bidirectional bus.
//   It takes one read or write request at a time and runs one bus cycle:
//   IDLE -> SETUP (SETUP_CYC cycles) -> ACCESS (until ready) -> TURNAROUND.
//
//   Ports
//     clock : single clock, rising edge
//     reset : asynchronous, active-high
//     bus   : cpu_bus_master_if.master
//             core side req/req_we/req_addr/req_wdata -> busy/ack/rdata/err
//             bus side  address/rw/strobe, ready from the slave
//     data  : bidirectional data bus. It is driven only during the SETUP and
//             ACCESS phases of a write, and is high-Z otherwise.
//
//   Parameters: ADDR_W, DATA_W, SETUP_CYC (1..15), TIMEOUT (1..255)
//
//   Optional feature: define BUS_TIMEOUT_EN to abort ACCESS after TIMEOUT
//   cycles without ready. In that case err=1 is reported with the ack.
//   When BUS_TIMEOUT_EN is not defined, err is tied low and there is no
//   timeout counter.
//
//   Every output, including the data drive enable, comes straight from a
//   flop. There is therefore no combinational path from ready to the bus.
// ---------------------------------------------------------------------------
module cpu_bus_master #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int SETUP_CYC = 1,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clock,
    input  logic                 reset,
    cpu_bus_master_if.master     bus,
    inout  wire  [DATA_W-1:0]    data
);

    if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup
        $error("cpu_bus_master: SETUP_CYC must be in 1..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("cpu_bus_master: TIMEOUT must be in 1..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_TURN
    } state_t;

    localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYC - 1);

    state_t            state_reg,     state_next;
    logic              we_reg,        we_next;
    logic [ADDR_W-1:0] address_reg,   address_next;
    logic [DATA_W-1:0] wdata_reg,     wdata_next;
    logic [DATA_W-1:0] rdata_reg,     rdata_next;
    logic              rw_reg,        rw_next;
    logic              strobe_reg,    strobe_next;
    logic              data_oe_reg,   data_oe_next;
    logic              busy_reg,      busy_next;
    logic              ack_reg,       ack_next;
    logic [3:0]        setup_cnt_reg, setup_cnt_next;

`ifdef BUS_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    logic [7:0]        acc_cnt_reg,   acc_cnt_next;
    logic              err_reg,       err_next;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_next     = state_reg;
        we_next        = we_reg;
        address_next   = address_reg;
        wdata_next     = wdata_reg;
        rdata_next     = rdata_reg;
        rw_next        = rw_reg;
        strobe_next    = strobe_reg;
        data_oe_next   = data_oe_reg;
        ack_next       = 1'b0;
        setup_cnt_next = setup_cnt_reg;
`ifdef BUS_TIMEOUT_EN
        acc_cnt_next   = acc_cnt_reg;
        err_next       = 1'b0;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (bus.req) begin
                    we_next        = bus.req_we;
                    address_next   = bus.req_addr;
                    wdata_next     = bus.req_wdata;
                    rw_next        = ~bus.req_we;
                    // The write drive starts with SETUP. This gives the
                    // slave a stable value before strobe rises.
                    data_oe_next   = bus.req_we;
                    setup_cnt_next = SETUP_LOAD;
                    state_next     = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (setup_cnt_reg == 4'd0) begin
                    strobe_next  = 1'b1;
`ifdef BUS_TIMEOUT_EN
                    acc_cnt_next = 8'd0;
`endif
                    state_next   = ST_ACCESS;
                end else begin
                    setup_cnt_next = setup_cnt_reg - 4'd1;
                end
            end

            ST_ACCESS: begin
                if (bus.ready) begin
                    // ready has priority over a timeout that expires on the
                    // same edge.
                    strobe_next  = 1'b0;
                    data_oe_next = 1'b0;
                    rw_next      = 1'b1;
                    ack_next     = 1'b1;
                    if (!we_reg) begin
                        rdata_next = data;
                    end
                    state_next   = ST_TURN;
`ifdef BUS_TIMEOUT_EN
                end else if (acc_cnt_reg == TIMEOUT_LAST) begin
                    // Abort. rdata keeps its previous value.
                    strobe_next  = 1'b0;
                    data_oe_next = 1'b0;
                    rw_next      = 1'b1;
                    ack_next     = 1'b1;
                    err_next     = 1'b1;
                    state_next   = ST_TURN;
                end else begin
                    acc_cnt_next = acc_cnt_reg + 8'd1;
`endif
                end
            end

            ST_TURN: begin
                // The data bus is released for one cycle before any
                // following transfer can start.
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            we_reg        <= 1'b0;
            address_reg   <= '0;
            wdata_reg     <= '0;
            rdata_reg     <= '0;
            rw_reg        <= 1'b1;
            strobe_reg    <= 1'b0;
            data_oe_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            ack_reg       <= 1'b0;
            setup_cnt_reg <= 4'd0;
        end else begin
            state_reg     <= state_next;
            we_reg        <= we_next;
            address_reg   <= address_next;
            wdata_reg     <= wdata_next;
            rdata_reg     <= rdata_next;
            rw_reg        <= rw_next;
            strobe_reg    <= strobe_next;
            data_oe_reg   <= data_oe_next;
            busy_reg      <= busy_next;
            ack_reg       <= ack_next;
            setup_cnt_reg <= setup_cnt_next;
        end
    end

`ifdef BUS_TIMEOUT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_cnt_reg <= 8'd0;
            err_reg     <= 1'b0;
        end else begin
            acc_cnt_reg <= acc_cnt_next;
            err_reg     <= err_next;
        end
    end
    assign bus.err = err_reg;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.address = address_reg;
    assign bus.rw      = rw_reg;
    assign bus.strobe  = strobe_reg;
    assign bus.busy    = busy_reg;
    assign bus.ack     = ack_reg;
    assign bus.rdata   = rdata_reg;

    assign data = data_oe_reg ? wdata_reg : {DATA_W{1'bz}};

endmodule

// File: tb/tb_cpu_bus_master.sv
module tb_cpu_bus_master;
    localparam int AW = 16;
    localparam int DW = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    cpu_bus_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

    wire  [DW-1:0] data;
    logic [DW-1:0] slv_val = '0;
    // The slave drives read data only while the master strobes a read.
    wire           slv_oe = bus_if.strobe & bus_if.rw;
    assign data = slv_oe ? slv_val : {DW{1'bz}};

    cpu_bus_master #(
        .ADDR_W(AW), .DATA_W(DW), .SETUP_CYC(1), .TIMEOUT(15)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if.master),
        .data  (data)
    );

    int checks     = 0;
    int failures   = 0;
    int acks_seen  = 0;
    int ack_base   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle. Sampling is done 1 ns after the edge. Every cycle
    // also checks that the master never drives the bus together with the
    // slave, and never drives it during a read.
    task automatic step();
        @(posedge clock);
        #1;
        if (bus_if.ack) acks_seen++;
        $display("cyc t=%0t st=%0d busy=%b ack=%b err=%b addr=%h rw=%b stb=%b oe=%b data=%h rdata=%h",
                 $time, dut.state_reg, bus_if.busy, bus_if.ack, bus_if.err, bus_if.address,
                 bus_if.rw, bus_if.strobe, dut.data_oe_reg, data, bus_if.rdata);
        chk("bus_contention", 32'(dut.data_oe_reg & slv_oe), 32'd0);
        chk("drive_while_rw1", 32'(dut.data_oe_reg & bus_if.rw), 32'd0);
    endtask

    initial begin
        bus_if.req       = 1'b0;
        bus_if.req_we    = 1'b0;
        bus_if.req_addr  = '0;
        bus_if.req_wdata = '0;
        bus_if.ready     = 1'b0;

        // ---------------- reset state ----------------
        step();
        chk("rst_busy",    32'(bus_if.busy),    32'd0);
        chk("rst_ack",     32'(bus_if.ack),     32'd0);
        chk("rst_rw",      32'(bus_if.rw),      32'd1);
        chk("rst_strobe",  32'(bus_if.strobe),  32'd0);
        chk("rst_address", 32'(bus_if.address), 32'd0);
        chk("rst_rdata",   32'(bus_if.rdata),   32'd0);
        chk("rst_err",     32'(bus_if.err),     32'd0);
        chk("rst_oe",      32'(dut.data_oe_reg), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        step();

        // ---------------- 1: async reset mid-ACCESS of a write ----------------
        bus_if.req = 1'b1; bus_if.req_we = 1'b1;
        bus_if.req_addr = 16'h0ABC; bus_if.req_wdata = 16'h1357; bus_if.ready = 1'b0;
        step();                                   // SETUP
        bus_if.req = 1'b0;
        step();                                   // ACCESS
        chk("t1_strobe_before", 32'(bus_if.strobe), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t1_strobe", 32'(bus_if.strobe),    32'd0);
        chk("t1_oe",     32'(dut.data_oe_reg),  32'd0);
        chk("t1_rw",     32'(bus_if.rw),        32'd1);
        chk("t1_busy",   32'(bus_if.busy),      32'd0);
        chk("t1_ack",    32'(bus_if.ack),       32'd0);
        chk("t1_addr",   32'(bus_if.address),   32'd0);
        ack_base = acks_seen;
        step();
        @(negedge clock);
        reset = 1'b0;
        step(); step(); step();
        chk("t1_no_ack", 32'(acks_seen - ack_base), 32'd0);
        chk("t1_idle",   32'(bus_if.busy), 32'd0);

        // ---------------- 2: single write ----------------
        bus_if.req = 1'b1; bus_if.req_we = 1'b1;
        bus_if.req_addr = 16'h1234; bus_if.req_wdata = 16'hBEEF;
        bus_if.ready = 1'b1;                      // high early: must be ignored in SETUP
        step();                                   // edge N -> SETUP
        bus_if.req = 1'b0;
        chk("t2_setup_busy",   32'(bus_if.busy),    32'd1);
        chk("t2_setup_addr",   32'(bus_if.address), 32'h1234);
        chk("t2_setup_rw",     32'(bus_if.rw),      32'd0);
        chk("t2_setup_strobe", 32'(bus_if.strobe),  32'd0);
        chk("t2_setup_oe",     32'(dut.data_oe_reg), 32'd1);
        chk("t2_setup_data",   32'(data),           32'hBEEF);
        step();                                   // N+1 -> ACCESS
        chk("t2_acc_strobe",   32'(bus_if.strobe),  32'd1);
        chk("t2_acc_data",     32'(data),           32'hBEEF);
        chk("t2_acc_ack",      32'(bus_if.ack),     32'd0);
        step();                                   // N+2 ready sampled -> TURNAROUND
        chk("t2_turn_ack",     32'(bus_if.ack),     32'd1);
        chk("t2_turn_strobe",  32'(bus_if.strobe),  32'd0);
        chk("t2_turn_oe",      32'(dut.data_oe_reg), 32'd0);
        chk("t2_turn_rw",      32'(bus_if.rw),      32'd1);
        chk("t2_turn_addr",    32'(bus_if.address), 32'h1234);
        chk("t2_turn_busy",    32'(bus_if.busy),    32'd1);
        chk("t2_turn_err",     32'(bus_if.err),     32'd0);
        chk("t2_turn_rdata",   32'(bus_if.rdata),   32'd0);
        step();                                   // IDLE
        chk("t2_idle_ack",     32'(bus_if.ack),     32'd0);
        chk("t2_idle_busy",    32'(bus_if.busy),    32'd0);

        // ---------------- 3: read with 4 wait states ----------------
        slv_val = 16'hA5A5;
        bus_if.req = 1'b1; bus_if.req_we = 1'b0;
        bus_if.req_addr = 16'h0042; bus_if.ready = 1'b0;
        step();                                   // SETUP
        bus_if.req = 1'b0;
        chk("t3_setup_rw",  32'(bus_if.rw),  32'd1);
        chk("t3_setup_oe",  32'(dut.data_oe_reg), 32'd0);
        step();                                   // ACCESS cycle 1
        for (int i = 0; i < 4; i++) begin
            chk("t3_wait_strobe", 32'(bus_if.strobe), 32'd1);
            chk("t3_wait_ack",    32'(bus_if.ack),    32'd0);
            step();
        end
        chk("t3_strobe5",   32'(bus_if.strobe), 32'd1);
        chk("t3_rdata_old", 32'(bus_if.rdata),  32'd0);
        bus_if.ready = 1'b1;
        step();                                   // TURNAROUND
        chk("t3_ack",   32'(bus_if.ack),   32'd1);
        chk("t3_rdata", 32'(bus_if.rdata), 32'hA5A5);
        chk("t3_err",   32'(bus_if.err),   32'd0);
        chk("t3_strobe_off", 32'(bus_if.strobe), 32'd0);
        step();                                   // IDLE

        // ---------------- 4: write then read back-to-back ----------------
        bus_if.req = 1'b1; bus_if.req_we = 1'b1;
        bus_if.req_addr = 16'h0010; bus_if.req_wdata = 16'h1111; bus_if.ready = 1'b1;
        slv_val = 16'h5A5A;
        step();                                   // SETUP (write)
        bus_if.req = 1'b0;
        step();                                   // ACCESS (write)
        chk("t4_wr_data", 32'(data), 32'h1111);
        step();                                   // TURNAROUND: nobody drives
        chk("t4_turn_master_z", 32'(dut.data_oe_reg), 32'd0);
        chk("t4_turn_slave_z",  32'(slv_oe),          32'd0);
        chk("t4_turn_ack",      32'(bus_if.ack),      32'd1);
        chk("t4_rdata_kept",    32'(bus_if.rdata),    32'hA5A5);
        bus_if.req = 1'b1; bus_if.req_we = 1'b0; bus_if.req_addr = 16'h0020;
        step();                                   // IDLE
        step();                                   // SETUP (read)
        bus_if.req = 1'b0;
        chk("t4_rd_addr", 32'(bus_if.address), 32'h0020);
        chk("t4_rd_oe",   32'(dut.data_oe_reg), 32'd0);
        step();                                   // ACCESS (read)
        chk("t4_rd_bus",  32'(data), 32'h5A5A);
        step();                                   // TURNAROUND
        chk("t4_rd_rdata", 32'(bus_if.rdata), 32'h5A5A);
        chk("t4_rd_ack",   32'(bus_if.ack),   32'd1);
        step();                                   // IDLE

        // ---------------- 6: req held across 3 transfers ----------------
        slv_val = 16'h0F0F;
        bus_if.ready = 1'b1; bus_if.req_we = 1'b0;
        bus_if.req = 1'b1; bus_if.req_addr = 16'h0100;
        ack_base = acks_seen;
        for (int k = 0; k < 3; k++) begin
            step();                               // SETUP
            chk("t6_setup_addr", 32'(bus_if.address), 32'(16'h0100 + 16'(k * 16)));
            bus_if.req_addr = 16'h0100 + 16'(k * 16) + 16'h0008;
            step();                               // ACCESS
            chk("t6_acc_addr", 32'(bus_if.address), 32'(16'h0100 + 16'(k * 16)));
            bus_if.req_addr = 16'h0100 + 16'((k + 1) * 16);
            step();                               // TURNAROUND
            chk("t6_ack", 32'(bus_if.ack), 32'd1);
            step();                               // IDLE
            chk("t6_idle", 32'(bus_if.busy), 32'd0);
            if (k == 2) bus_if.req = 1'b0;
        end
        step(); step(); step();
        chk("t6_ack_count", 32'(acks_seen - ack_base), 32'd3);
        chk("t6_quiet",     32'(bus_if.busy), 32'd0);
        chk("t6_rdata",     32'(bus_if.rdata), 32'h0F0F);

`ifdef BUS_TIMEOUT_EN
        // ---------------- 5: timeout, then ready on the last cycle ----------------
        slv_val = 16'h3C3C;
        bus_if.ready = 1'b0; bus_if.req = 1'b1; bus_if.req_we = 1'b0;
        bus_if.req_addr = 16'h0200;
        step();                                   // SETUP
        bus_if.req = 1'b0;
        step();                                   // ACCESS cycle 1
        for (int i = 1; i < 15; i++) begin
            chk("t5_wait_strobe", 32'(bus_if.strobe), 32'd1);
            chk("t5_wait_ack",    32'(bus_if.ack),    32'd0);
            step();
        end
        chk("t5_strobe15", 32'(bus_if.strobe), 32'd1);
        step();                                   // TURNAROUND after timeout
        chk("t5_to_ack",   32'(bus_if.ack),   32'd1);
        chk("t5_to_err",   32'(bus_if.err),   32'd1);
        chk("t5_to_rdata", 32'(bus_if.rdata), 32'h0F0F);
        step();                                   // IDLE
        chk("t5_err_clear", 32'(bus_if.err), 32'd0);

        bus_if.req = 1'b1;
        step();                                   // SETUP
        bus_if.req = 1'b0;
        step();                                   // ACCESS cycle 1
        for (int i = 1; i < 15; i++) begin
            step();
        end
        chk("t5b_strobe15", 32'(bus_if.strobe), 32'd1);
        bus_if.ready = 1'b1;
        step();                                   // ready wins on the expiring edge
        chk("t5b_ack",   32'(bus_if.ack),   32'd1);
        chk("t5b_err",   32'(bus_if.err),   32'd0);
        chk("t5b_rdata", 32'(bus_if.rdata), 32'h3C3C);
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
